arya_mem_loader: RTL and testbench

Host-side initiator for the arya core's debug memory port. While holding `debug_on` high it streams a program image from a valid/ready source into core memory over `mem_addr_in`/`mem_data_in`. When configured, it then reads the image back through `mem_addr_out`/`mem_data_out` and checks a rotate-XOR checksum. It sits between the board-level host link and the `arya` top; the core runs only when `debug_on` is low.

---
 rtl/arya_pkg.sv | 27 ++
 rtl/arya_mem_loader_if.sv | 26 ++
 rtl/arya_csum_acc.sv | 30 +++
 rtl/arya_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_arya_mem_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/arya_pkg.sv
// arya_pkg: shared widths, loader state encoding and the rotate-XOR checksum
// step used by arya_mem_loader (optional verify path: ARYA_LOADER_VERIFY_EN).
package arya_pkg;

   localparam int unsigned ARYA_ADDR_W = 10;
   localparam int unsigned ARYA_DATA_W = 64;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      VERIFY,
      DONE,
      ERR
   } loader_state_t;

   // cs XOR rotl(data, rot); the doubled word makes the rotate a plain shift
   function automatic logic [ARYA_DATA_W-1:0] csum_step(
      input logic [ARYA_DATA_W-1:0] cs,
      input logic [ARYA_DATA_W-1:0] data,
      input logic [5:0]             rot
   );
      logic [2*ARYA_DATA_W-1:0] dbl;
      dbl = {data, data} << rot;
      return cs ^ dbl[2*ARYA_DATA_W-1 -: ARYA_DATA_W];
   endfunction

endpackage

// File: rtl/arya_mem_loader_if.sv
// arya_mem_loader_if: source stream and core debug memory port of the loader.
// master = loader side, slave = host source / core side.
interface arya_mem_loader_if import arya_pkg::*; #(
   parameter int unsigned ADDR_W = ARYA_ADDR_W,
   parameter int unsigned DATA_W = ARYA_DATA_W
);
   logic              src_valid;
   logic [DATA_W-1:0] src_data;
   logic              src_ready;
   logic              debug_on;
   logic [ADDR_W-1:0] mem_addr_in;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [DATA_W-1:0] mem_data_out;

   modport master (
      input  src_valid, src_data, mem_addr_out, mem_data_out,
      output src_ready, debug_on, mem_addr_in, mem_data_in, mem_we
   );

   modport slave (
      output src_valid, src_data, mem_addr_out, mem_data_out,
      input  src_ready, debug_on, mem_addr_in, mem_data_in, mem_we
   );
endinterface

// File: rtl/arya_csum_acc.sv
// arya_csum_acc: rotate-XOR checksum accumulator; clear has priority over en.
module arya_csum_acc import arya_pkg::*; (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   en,
   input  logic [ARYA_DATA_W-1:0] data,
   input  logic [5:0]             addr,
   output logic [ARYA_DATA_W-1:0] acc
);
   logic [ARYA_DATA_W-1:0] acc_q, acc_d;

   // next accumulator value
   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = csum_step(acc_q, data, addr);
      end
   end

   // accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc = acc_q;
endmodule

// File: rtl/arya_mem_loader.sv
// arya_mem_loader: streams a program image into the arya core's debug memory
// port while holding the core halted. Optional read-back checksum verify is
// built when ARYA_LOADER_VERIFY_EN is defined.
module arya_mem_loader import arya_pkg::*; #(
   parameter int unsigned ADDR_W = ARYA_ADDR_W,
   parameter int unsigned DATA_W = ARYA_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W:0]     load_len,
   arya_mem_loader_if.master   bus,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     word_count
);
   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   loader_state_t     state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic              start_ok_q, start_ok_d;
   logic              src_ready;
   logic              beat;
   logic              start_acc;

`ifdef ARYA_LOADER_VERIFY_EN
   logic [ADDR_W:0]   vcnt_q, vcnt_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              rvld_q, rvld_d;
   logic [DATA_W-1:0] cs_wr, cs_rd;
`else
   logic              unused_rd;
   assign unused_rd = ^{bus.mem_addr_out, bus.mem_data_out};
`endif

   assign src_ready = (state_q == LOAD) && (word_count_q < len_q);
   assign beat      = bus.src_valid & src_ready;
   // start_ok_q keeps a start coincident with reset release from being taken
   assign start_acc = start & start_ok_q & (state_q inside {IDLE, DONE, ERR});

   // next-state, write port and verify sequencing
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_count_d = word_count_q;
      addr_d       = addr_q;
      data_d       = data_q;
      we_d         = 1'b0;
      start_ok_d   = 1'b1;
`ifdef ARYA_LOADER_VERIFY_EN
      vcnt_d       = vcnt_q;
      raddr_d      = raddr_q;
      rvld_d       = 1'b0;
`endif
      if (start_acc) begin
         state_d      = LOAD;
         len_d        = (load_len > MAX_LEN) ? MAX_LEN : load_len;
         word_count_d = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (beat) begin
                  addr_d       = word_count_q[ADDR_W-1:0];
                  data_d       = bus.src_data;
                  we_d         = 1'b1;
                  word_count_d = word_count_q + CNT_ONE;
               end else if (word_count_q == len_q) begin
`ifdef ARYA_LOADER_VERIFY_EN
                  state_d = VERIFY;
                  addr_d  = '0;
                  vcnt_d  = '0;
`else
                  state_d = DONE;
`endif
               end
            end
`ifdef ARYA_LOADER_VERIFY_EN
            VERIFY: begin
               vcnt_d = vcnt_q + CNT_ONE;
               if (vcnt_q < len_q) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  raddr_d = addr_q;
                  rvld_d  = 1'b1;
               end
               if (rvld_q && (bus.mem_addr_out != raddr_q)) begin
                  state_d = ERR;
               end else if (vcnt_q == len_q + CNT_ONE) begin
                  state_d = (cs_wr == cs_rd) ? DONE : ERR;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         word_count_q <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         start_ok_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_count_q <= word_count_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         start_ok_q   <= start_ok_d;
      end
   end

`ifdef ARYA_LOADER_VERIFY_EN
   // verify read tracking registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vcnt_q  <= '0;
         raddr_q <= '0;
         rvld_q  <= 1'b0;
      end else begin
         vcnt_q  <= vcnt_d;
         raddr_q <= raddr_d;
         rvld_q  <= rvld_d;
      end
   end

   arya_csum_acc u_csum_wr (
      .clk   (clk),
      .rst_n (reset),
      .clear (start_acc),
      .en    (beat),
      .data  (bus.src_data),
      .addr  (6'(word_count_q)),
      .acc   (cs_wr)
   );

   arya_csum_acc u_csum_rd (
      .clk   (clk),
      .rst_n (reset),
      .clear (start_acc),
      .en    (rvld_q),
      .data  (bus.mem_data_out),
      .addr  (6'(bus.mem_addr_out)),
      .acc   (cs_rd)
   );

   assign error = (state_q == ERR);
`else
   assign error = 1'b0;
`endif

   assign bus.src_ready   = src_ready;
   assign bus.debug_on    = (state_q != IDLE);
   assign bus.mem_addr_in = addr_q;
   assign bus.mem_data_in = data_q;
   assign bus.mem_we      = we_q;
   assign busy            = (state_q == LOAD) || (state_q == VERIFY);
   assign done            = (state_q == DONE);
   assign word_count      = word_count_q;
endmodule

// File: tb/tb_arya_mem_loader.sv
// tb_arya_mem_loader: table-driven and randomized loads against a simple
// core-memory model; expectations adapt to ARYA_LOADER_VERIFY_EN.
module tb_arya_mem_loader;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 64;
`ifdef ARYA_LOADER_VERIFY_EN
   localparam bit VEN = 1'b1;
`else
   localparam bit VEN = 1'b0;
`endif

   typedef struct {
      int len;
      int mode;    // 0: valid held, 1: valid every other cycle, 2: random
      int pat;     // 0: 0x11*(i+1), 1: random words
      bit corrupt; // core flips bit 0 of data read from address 2
      bit afault;  // core echoes a wrong read address
      bit poke;    // extra start pulse during LOAD
   } vec_t;

   typedef struct {
      int          addr;
      logic [63:0] data;
      int          edge_no;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   load_len = '0;
   logic          busy, done, error;
   logic [AW:0]   word_count;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   bit            corrupt_en = 1'b0;
   bit            afault_en = 1'b0;
   logic [63:0]   mem [0:1023];
   wr_t           wr_log[$];

   arya_mem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   arya_mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .load_len   (load_len),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // core memory model with one-cycle read latency and fault knobs
   always @(posedge clk) begin
      if (bus.debug_on && bus.mem_we) mem[bus.mem_addr_in] <= bus.mem_data_in;
      bus.mem_addr_out <= afault_en ? (bus.mem_addr_in ^ 10'h1) : bus.mem_addr_in;
      bus.mem_data_out <= mem[bus.mem_addr_in] ^
                          ((corrupt_en && bus.mem_addr_in == 10'd2) ? 64'h1 : 64'h0);
   end

   // write monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.mem_we) wr_log.push_back('{int'(bus.mem_addr_in), bus.mem_data_in, cyc});
   end

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_load(input vec_t v, input string tag);
      int          eff, idx, k, budget, t0, t_end, exp_t, ready_bad, wr_bad;
      bit          finished, vld, exp_ready, beat, exp_err;
      logic [63:0] words[$];
      wr_t         exp_wr[$];
      eff = (v.len > 1024) ? 1024 : v.len;
      for (int i = 0; i < eff; i++)
         words.push_back(v.pat == 0 ? 64'(i + 1) * 64'h11 : {$urandom, $urandom});
      exp_err = VEN && ((v.corrupt && eff > 2) || (v.afault && eff > 0));
      exp_t   = eff + 1 + (VEN ? ((v.afault && eff > 0) ? 2 : eff + 2) : 0);
      budget  = 6 * eff + 60;

      @(negedge clk);
      corrupt_en    = v.corrupt;
      afault_en     = v.afault;
      load_len      = (AW+1)'(v.len);
      start         = 1'b1;
      bus.src_valid = 1'($urandom_range(0, 1));
      t0            = cyc + 1;
      wr_log.delete();
      @(negedge clk);
      start     = 1'b0;
      idx       = 0;
      k         = 0;
      finished  = 1'b0;
      t_end     = 0;
      ready_bad = 0;
      while (!finished && k < budget) begin
         if (done || error) begin
            finished = 1'b1;
            t_end    = cyc;
         end else begin
            case (v.mode)
               0:       vld = 1'b1;
               1:       vld = (k % 2 == 0);
               default: vld = ($urandom_range(0, 3) != 0);
            endcase
            bus.src_valid = vld;
            bus.src_data  = (idx < eff) ? words[idx] : {$urandom, $urandom};
            if (v.poke && k == 2) begin
               start    = 1'b1;
               load_len = (AW+1)'(3);
            end
            exp_ready = (idx < eff);
            if (bus.src_ready !== exp_ready) ready_bad++;
            beat = vld && exp_ready;
            if (beat) exp_wr.push_back('{idx, words[idx], cyc + 1});
            @(negedge clk);
            start = 1'b0;
            if (beat) idx++;
            k++;
         end
      end
      bus.src_valid = 1'b0;

      check({tag, " finished"}, finished, 1);
      check({tag, " done"}, done, !exp_err);
      check({tag, " error"}, error, exp_err);
      check({tag, " debug_on"}, bus.debug_on, 1);
      check({tag, " busy"}, busy, 0);
      check({tag, " word_count"}, word_count, eff);
      check({tag, " src_ready"}, ready_bad, 0);
      check({tag, " write count"}, wr_log.size(), exp_wr.size());
      wr_bad = 0;
      for (int i = 0; i < exp_wr.size(); i++) begin
         if (i >= wr_log.size()) wr_bad++;
         else if (wr_log[i] != exp_wr[i]) wr_bad++;
      end
      check({tag, " write addr/data/timing"}, wr_bad, 0);
      if (v.mode == 0) check({tag, " cycles to end"}, t_end - t0, exp_t);
   endtask

   vec_t tbl[9];

   initial begin
      vec_t rv;
      bus.src_valid = 1'b0;
      bus.src_data  = '0;

      tbl[0] = '{len: 4,    mode: 0, pat: 0, corrupt: 0, afault: 0, poke: 0};
      tbl[1] = '{len: 4,    mode: 1, pat: 0, corrupt: 0, afault: 0, poke: 0};
      tbl[2] = '{len: 0,    mode: 0, pat: 1, corrupt: 0, afault: 0, poke: 0};
      tbl[3] = '{len: 1100, mode: 0, pat: 1, corrupt: 0, afault: 0, poke: 0};
      tbl[4] = '{len: 8,    mode: 2, pat: 1, corrupt: 0, afault: 0, poke: 0};
      tbl[5] = '{len: 70,   mode: 2, pat: 1, corrupt: 0, afault: 0, poke: 0};
      tbl[6] = '{len: 5,    mode: 0, pat: 0, corrupt: 1, afault: 0, poke: 0};
      tbl[7] = '{len: 5,    mode: 0, pat: 0, corrupt: 0, afault: 1, poke: 0};
      tbl[8] = '{len: 6,    mode: 0, pat: 1, corrupt: 0, afault: 0, poke: 1};

      // reset state
      #1;
      check("rst debug_on", bus.debug_on, 0);
      check("rst src_ready", bus.src_ready, 0);
      check("rst mem_we", bus.mem_we, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst error", error, 0);
      check("rst word_count", word_count, 0);
      check("rst mem_addr_in", bus.mem_addr_in, 0);
      check("rst mem_data_in", bus.mem_data_in, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) do_load(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 8; i++) begin
         rv.len     = $urandom_range(0, 80);
         rv.mode    = $urandom_range(0, 2);
         rv.pat     = 1;
         rv.corrupt = ($urandom_range(0, 3) == 0);
         rv.afault  = ($urandom_range(0, 5) == 0);
         rv.poke    = ($urandom_range(0, 3) == 0);
         do_load(rv, $sformatf("rnd%0d", i));
      end

      // reset in the middle of an 8-word load
      @(negedge clk);
      corrupt_en    = 1'b0;
      afault_en     = 1'b0;
      load_len      = (AW+1)'(8);
      start         = 1'b1;
      @(negedge clk);
      start         = 1'b0;
      bus.src_valid = 1'b1;
      bus.src_data  = 64'hA5;
      repeat (3) @(negedge clk);
      check("midload word_count", word_count, 3);
      #2 reset = 1'b0;
      #1;
      check("async debug_on", bus.debug_on, 0);
      check("async src_ready", bus.src_ready, 0);
      check("async mem_we", bus.mem_we, 0);
      check("async busy", busy, 0);
      check("async done", done, 0);
      check("async error", error, 0);
      check("async word_count", word_count, 0);
      check("async mem_addr_in", bus.mem_addr_in, 0);
      check("async mem_data_in", bus.mem_data_in, 0);
      @(negedge clk);
      bus.src_valid = 1'b0;
      reset         = 1'b1;
      start         = 1'b1;
      load_len      = (AW+1)'(8);
      @(negedge clk);
      start = 1'b0;
      check("start at reset release busy", busy, 0);
      check("start at reset release debug_on", bus.debug_on, 0);
      rv = '{len: 8, mode: 0, pat: 1, corrupt: 0, afault: 0, poke: 0};
      do_load(rv, "after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
